seq_divider: RTL and testbench

//   Multi-cycle radix-2 restoring divider. It is the responder side of the EX-stage divide

---
 rtl/seq_divider.sv | 141 ++++++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Radix-2 restoring divider answering the EX-stage DIV/DIVU handshake.
// One quotient bit per cycle; result_o = {remainder, quotient}.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start_i with a non-zero divisor
// DIVZERO | divisor was zero; answer {0,0} after a fixed two edges
// ON      | one shift-subtract step per cycle, counter = step index
// END     | result_o valid, ready_o=1; held until start_i drops
module seq_divider #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvs;
  logic              neg_q;
  logic              neg_r;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic              fits;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] quo_fix;

  always_comb begin
    a_neg   = signed_div_i & opdata1_i[DATA_W-1];
    b_neg   = signed_div_i & opdata2_i[DATA_W-1];
    a_abs   = a_neg ? -opdata1_i : opdata1_i;
    b_abs   = b_neg ? -opdata2_i : opdata2_i;
    // quo starts as the dividend; its MSB feeds the partial remainder each step
    trial   = {rem, quo[DATA_W-1]};
    diff    = trial - {1'b0, dvs};
    fits    = (trial >= {1'b0, dvs});
    rem_nxt = fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_nxt = {quo[DATA_W-2:0], fits};
    rem_fix = neg_r ? -rem_nxt : rem_nxt;
    quo_fix = neg_q ? -quo_nxt : quo_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      counter  <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            counter <= '0;
            if (opdata2_i == '0) begin
              state <= S_DIVZERO;
            end else begin
              state <= S_ON;
              rem   <= '0;
              quo   <= a_abs;
              dvs   <= b_abs;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        S_DIVZERO: begin
          // extra edge keeps the divide-by-zero turnaround at two edges
          if (counter == '0) begin
            counter <= CNT_W'(1);
          end else begin
            state    <= S_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state    <= S_IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            rem     <= rem_nxt;
            quo     <= quo_nxt;
            counter <= counter + CNT_W'(1);
            if (counter == LAST_STEP) begin
              state    <= S_END;
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            state    <= S_IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: each task drives one scenario and checks
// latency and {remainder, quotient} against hand-computed values.
module tb_seq_divider;

  logic        clk;
  logic        resetn;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp;
  int n_fail;

  seq_divider #(.DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch before edge E0, wait for ready, hold start for `hold` cycles, then release.
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input int exp_lat, input int hold);
    int lat;
    lat = -1;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (result_o !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", name, result_o, exp_res);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ready_o !== 1'b1 || result_o !== exp_res) begin
        n_fail++;
        $display("FAIL %s hold: got ready=%b result=%h expected ready=1 result=%h",
                 name, ready_o, result_o, exp_res);
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL %s release: got ready=%b result=%h expected ready=0 result=0",
               name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    #12;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset: got ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32, 3);
    run_op("divu_ffffffff_10", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 32, 0);
    run_op("divu_80000000_ffffffff", 1'b0, 32'h80000000, 32'hFFFFFFFF,
           {32'h80000000, 32'h0}, 32, 0);
  endtask

  task automatic test_signed();
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32, 0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 32, 0);
    run_op("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 32, 0);
    run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 32, 0);
  endtask

  task automatic test_divzero();
    run_op("divu_by_zero", 1'b0, 32'hFFFFFFFF, 32'h0, 64'h0, 2, 2);
    run_op("div_by_zero", 1'b1, 32'h80000001, 32'h0, 64'h0, 2, 0);
  endtask

  task automatic test_annul();
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    // start stays high with annul: the IDLE cycles after the flush must not restart
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
        n_fail++;
        $display("FAIL annul cycle %0d: got ready=%b result=%h expected ready=0 result=0",
                 i, ready_o, result_o);
      end
    end
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk);
    run_op("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, 0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid_on: got ready=%b result=%h expected ready=0 result=0",
               ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    // reset while result is valid must clear it without waiting for an edge
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    for (int k = 0; k < 40 && ready_o !== 1'b1; k++) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1 || result_o !== {32'd0, 32'd10}) begin
      n_fail++;
      $display("FAIL pre_reset_end: got ready=%b result=%h expected ready=1 result=%h",
               ready_o, result_o, {32'd0, 32'd10});
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_in_end: got ready=%b result=%h expected ready=0 result=0",
               ready_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_op("after_reset_1000_3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 32, 0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 1'b1, 32'hFFFFFFF0, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFB}, 32, 0);
    run_op("b2b_second", 1'b0, 32'd12345, 32'd100, {32'd45, 32'd123}, 32, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_annul();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
